// File: rtl/net_sequencer_if.sv
// Handshake bundle between the layer scheduler and the surrounding accelerator.
// The scheduler uses slave; the layer controllers and host side use master.
interface net_sequencer_if #(
  parameter int NUM_LAYERS = 4
);
  logic                  start;
  logic                  abort;
  logic                  stall;
  logic [NUM_LAYERS-1:0] finish_in;
  logic [NUM_LAYERS-1:0] en_ctrl;
  logic [NUM_LAYERS-1:0] layer_rst;
  logic                  buf_sel;
  logic [2:0]            cur_layer;
  logic                  busy;
  logic                  done;
  logic [31:0]           cycle_count;

  modport master (
    output start, abort, stall, finish_in,
    input  en_ctrl, layer_rst, buf_sel, cur_layer, busy, done, cycle_count
  );

  modport slave (
    input  start, abort, stall, finish_in,
    output en_ctrl, layer_rst, buf_sel, cur_layer, busy, done, cycle_count
  );
endinterface

// File: rtl/net_sequencer.sv
// Layer scheduler: runs the active layer controllers one at a time, drains the
// write-back pipeline after each, and swaps the ping-pong feature-map buffers.
module net_sequencer #(
  parameter int                    NUM_LAYERS   = 4,
  parameter logic [NUM_LAYERS-1:0] ACTIVE_MASK  = 4'b1111,
  parameter int                    DRAIN_CYCLES = 3,
  parameter logic                  INIT_BUF     = 1'b0
) (
  input logic           clk,
  input logic           reset,
  net_sequencer_if.slave sq
);
  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_CLEAR, S_RUN, S_DRAIN, S_NEXT, S_DONE, S_ABORT
  } state_e;

  localparam logic [7:0] MASK8 = 8'(ACTIVE_MASK);
  localparam logic [2:0] LAST  = 3'(NUM_LAYERS - 1);
  localparam logic [3:0] DRAIN = 4'(DRAIN_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  cur_q, cur_d;
  logic        buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] cyc_q, cyc_d;

  // Padded to 8 so cur_q can index it directly for any NUM_LAYERS.
  logic [7:0]  fin8;
  assign fin8 = 8'(sq.finish_in);

  logic [31:0] cyc_inc;
  assign cyc_inc = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      S_IDLE: if (sq.start) begin
        cur_d   = 3'd0;
        buf_d   = INIT_BUF;
        cyc_d   = 32'd0;
        state_d = S_SEEK;
      end
      S_SEEK: begin
        if (MASK8[cur_q])      state_d = S_CLEAR;
        else if (cur_q == LAST) state_d = S_DONE;
        else                   cur_d   = cur_q + 3'd1;
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: if (!sq.stall) begin
        cyc_d = cyc_inc;
        if (fin8[cur_q]) begin
          if (DRAIN == 4'd0) state_d = S_NEXT;
          else begin
            cnt_d   = DRAIN;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: if (!sq.stall) begin
        cyc_d = cyc_inc;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_NEXT;
      end
      S_NEXT: begin
        buf_d = ~buf_q;
        if (cur_q == LAST) state_d = S_DONE;
        else begin
          cur_d   = cur_q + 3'd1;
          state_d = S_SEEK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything; buffer/layer bookkeeping is frozen with it.
    if (sq.abort && state_q != S_IDLE && state_q != S_ABORT) begin
      state_d = S_ABORT;
      cur_d   = cur_q;
      buf_d   = buf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cur_q   <= 3'd0;
      buf_q   <= INIT_BUF;
      cnt_q   <= 4'd0;
      cyc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
    end
  end

  logic en_st, clr_st, abt_st;
  assign en_st  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign clr_st = (state_q == S_CLEAR);
  assign abt_st = (state_q == S_ABORT);

  logic [NUM_LAYERS-1:0] en_w, rst_w;
  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_lane
    logic hit;
    assign hit      = (cur_q == 3'(i));
    assign en_w[i]  = en_st & hit & ~sq.stall;
    assign rst_w[i] = (clr_st & hit) | abt_st;
  end

  assign sq.en_ctrl     = en_w;
  assign sq.layer_rst   = rst_w;
  assign sq.buf_sel     = buf_q;
  assign sq.cur_layer   = cur_q;
  assign sq.busy        = (state_q != S_IDLE);
  assign sq.done        = (state_q == S_DONE);
  assign sq.cycle_count = cyc_q;
endmodule

// File: tb/tb_net_sequencer.sv
// Scoreboard bench: four sequencer configurations driven by directed layer
// timelines; a negedge monitor turns DUT activity into events checked in order.
module tb_net_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0] start_v;
  logic       abort, stall;
  logic [3:0] fin;

  net_sequencer_if #(.NUM_LAYERS(4)) if0 ();
  net_sequencer_if #(.NUM_LAYERS(4)) if1 ();
  net_sequencer_if #(.NUM_LAYERS(4)) if2 ();
  net_sequencer_if #(.NUM_LAYERS(4)) if3 ();

  assign if0.start = start_v[0]; assign if0.abort = abort; assign if0.stall = stall; assign if0.finish_in = fin;
  assign if1.start = start_v[1]; assign if1.abort = abort; assign if1.stall = stall; assign if1.finish_in = fin;
  assign if2.start = start_v[2]; assign if2.abort = abort; assign if2.stall = stall; assign if2.finish_in = fin;
  assign if3.start = start_v[3]; assign if3.abort = abort; assign if3.stall = stall; assign if3.finish_in = fin;

  net_sequencer #(.NUM_LAYERS(4), .ACTIVE_MASK(4'b1111), .DRAIN_CYCLES(3), .INIT_BUF(1'b0))
    u0 (.clk(clk), .reset(reset), .sq(if0.slave));
  net_sequencer #(.NUM_LAYERS(4), .ACTIVE_MASK(4'b0101), .DRAIN_CYCLES(3), .INIT_BUF(1'b1))
    u1 (.clk(clk), .reset(reset), .sq(if1.slave));
  net_sequencer #(.NUM_LAYERS(4), .ACTIVE_MASK(4'b1111), .DRAIN_CYCLES(0), .INIT_BUF(1'b0))
    u2 (.clk(clk), .reset(reset), .sq(if2.slave));
  net_sequencer #(.NUM_LAYERS(4), .ACTIVE_MASK(4'b0000), .DRAIN_CYCLES(3), .INIT_BUF(1'b0))
    u3 (.clk(clk), .reset(reset), .sq(if3.slave));

  logic [3:0]  en_a[4], rst_a[4];
  logic        busy_a[4], done_a[4], buf_a[4];
  logic [2:0]  cur_a[4];
  logic [31:0] cyc_a[4];

  assign en_a[0] = if0.en_ctrl;  assign rst_a[0] = if0.layer_rst; assign busy_a[0] = if0.busy;
  assign done_a[0] = if0.done;   assign buf_a[0] = if0.buf_sel;   assign cur_a[0] = if0.cur_layer;
  assign cyc_a[0] = if0.cycle_count;
  assign en_a[1] = if1.en_ctrl;  assign rst_a[1] = if1.layer_rst; assign busy_a[1] = if1.busy;
  assign done_a[1] = if1.done;   assign buf_a[1] = if1.buf_sel;   assign cur_a[1] = if1.cur_layer;
  assign cyc_a[1] = if1.cycle_count;
  assign en_a[2] = if2.en_ctrl;  assign rst_a[2] = if2.layer_rst; assign busy_a[2] = if2.busy;
  assign done_a[2] = if2.done;   assign buf_a[2] = if2.buf_sel;   assign cur_a[2] = if2.cur_layer;
  assign cyc_a[2] = if2.cycle_count;
  assign en_a[3] = if3.en_ctrl;  assign rst_a[3] = if3.layer_rst; assign busy_a[3] = if3.busy;
  assign done_a[3] = if3.done;   assign buf_a[3] = if3.buf_sel;   assign cur_a[3] = if3.cur_layer;
  assign cyc_a[3] = if3.cycle_count;

  localparam logic [1:0] K_EN = 2'd0, K_RST = 2'd1, K_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]  id;
    logic [1:0]  kind;
    logic [39:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic ev_t mk(input int id, input logic [1:0] kind, input logic [39:0] d);
    ev_t e;
    e.id = 2'(id); e.kind = kind; e.data = d;
    return e;
  endfunction

  task automatic push_en(input int id, input logic [3:0] m, input int len);
    exp_q.push_back(mk(id, K_EN, {32'(len), 4'b0000, m}));
  endtask
  task automatic push_rst(input int id, input logic [3:0] m);
    exp_q.push_back(mk(id, K_RST, {36'd0, m}));
  endtask
  task automatic push_done(input int id, input int cyc, input int tog, input int cur, input logic b);
    exp_q.push_back(mk(id, K_DONE, {32'(cyc), 4'(tog), 3'(cur), b}));
  endtask

  task automatic observe(input ev_t ev);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got id=%0d kind=%0d data=%h, expected no event", ev.id, ev.kind, ev.data);
    end else begin
      e = exp_q.pop_front();
      if (e !== ev) begin
        errors++;
        $display("FAIL event: got id=%0d kind=%0d data=%h, expected id=%0d kind=%0d data=%h",
                 ev.id, ev.kind, ev.data, e.id, e.kind, e.data);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor state, owned by the monitor process only.
  logic [3:0] prev_en[4]   = '{default: 4'd0};
  int         len[4]       = '{default: 0};
  int         tog[4]       = '{default: 0};
  logic       prev_busy[4] = '{default: 1'b0};
  logic       prev_buf[4]  = '{default: 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!prev_busy[i] && busy_a[i]) tog[i] = 0;
      else if (prev_busy[i] && busy_a[i] && buf_a[i] != prev_buf[i]) tog[i] = tog[i] + 1;
      if (prev_en[i] != 4'd0 && en_a[i] != prev_en[i])
        observe(mk(i, K_EN, {32'(len[i]), 4'b0000, prev_en[i]}));
      if (en_a[i] != 4'd0) len[i] = (en_a[i] == prev_en[i]) ? len[i] + 1 : 1;
      else                 len[i] = 0;
      if (rst_a[i] != 4'd0) begin
        observe(mk(i, K_RST, {36'd0, rst_a[i]}));
        checks++;
        if ((en_a[i] & rst_a[i]) != 4'd0 || !$onehot0(en_a[i])) begin
          errors++;
          $display("FAIL overlap dut%0d: got en=%b rst=%b, expected disjoint one-hot", i, en_a[i], rst_a[i]);
        end
      end
      if (done_a[i])
        observe(mk(i, K_DONE, {cyc_a[i], 4'(tog[i]), cur_a[i], buf_a[i]}));
      prev_en[i]   = en_a[i];
      prev_busy[i] = busy_a[i];
      prev_buf[i]  = buf_a[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input int id, input int layer);
    int n = 0;
    while (!en_a[id][layer] && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL wait_en dut%0d layer%0d: got no enable, expected enable within 200 cycles", id, layer);
    end
  endtask

  task automatic wait_done(input int id);
    int n = 0;
    while (!done_a[id] && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL wait_done dut%0d: got no done, expected done within 300 cycles", id);
    end
    tick();
  endtask

  // Layer controller model: finish pulsed in the n-th enabled cycle.
  task automatic run_layer(input int id, input int layer, input int n);
    wait_en(id, layer);
    repeat (n - 1) tick();
    fin = 4'(1 << layer);
    tick();
    fin = 4'd0;
  endtask

  task automatic pulse_start(input int id);
    start_v = 4'(1 << id);
    tick();
    start_v = 4'd0;
  endtask

  initial begin
    reset = 1'b1; start_v = 4'd0; abort = 1'b0; stall = 1'b0; fin = 4'd0;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_en",   {36'd0, en_a[0]},  40'd0);
    chk("rst_lrst", {36'd0, rst_a[0]}, 40'd0);
    chk("rst_busy", {39'd0, busy_a[0]}, 40'd0);
    chk("rst_done", {39'd0, done_a[0]}, 40'd0);
    chk("rst_cur",  {37'd0, cur_a[0]}, 40'd0);
    chk("rst_cyc",  {8'd0, cyc_a[0]},  40'd0);
    chk("rst_buf0", {39'd0, buf_a[0]}, 40'd0);
    chk("rst_buf1", {39'd0, buf_a[1]}, 40'd1);

    // Full run with a stray finish and a stray start.
    for (int i = 0; i < 4; i++) begin push_rst(0, 4'(1 << i)); push_en(0, 4'(1 << i), 13); end
    push_done(0, 52, 4, 3, 1'b0);
    pulse_start(0);
    chk("lat_seek_busy", {39'd0, busy_a[0]}, 40'd1);
    chk("lat_seek_rst",  {36'd0, rst_a[0]}, 40'd0);
    tick();
    chk("lat_clear_rst", {36'd0, rst_a[0]}, 40'd1);
    chk("lat_clear_en",  {36'd0, en_a[0]},  40'd0);
    tick();
    chk("lat_run_en",    {36'd0, en_a[0]},  40'd1);
    repeat (2) tick();
    fin = 4'b0100;
    tick();
    fin = 4'd0;
    repeat (6) tick();
    fin = 4'b0001;
    tick();
    fin = 4'd0;
    pulse_start(0);
    for (int i = 1; i < 4; i++) run_layer(0, i, 10);
    wait_done(0);
    chk("full_buf_end", {39'd0, buf_a[0]}, 40'd0);

    // Abort in layer-1 drain, with start in the same cycle.
    push_rst(0, 4'b0001); push_en(0, 4'b0001, 13);
    push_rst(0, 4'b0010); push_en(0, 4'b0010, 11);
    push_rst(0, 4'b1111);
    pulse_start(0);
    run_layer(0, 0, 10);
    run_layer(0, 1, 10);
    abort = 1'b1; start_v = 4'b0001;
    tick();
    abort = 1'b0; start_v = 4'd0;
    chk("abort_lrst", {36'd0, rst_a[0]}, 40'hF);
    chk("abort_en",   {36'd0, en_a[0]},  40'd0);
    chk("abort_buf",  {39'd0, buf_a[0]}, 40'd1);
    tick();
    chk("abort_idle", {39'd0, busy_a[0]}, 40'd0);
    chk("abort_done", {39'd0, done_a[0]}, 40'd0);

    // Restart, then reset mid-RUN.
    push_rst(0, 4'b0001); push_en(0, 4'b0001, 4);
    pulse_start(0);
    chk("restart_buf", {39'd0, buf_a[0]}, 40'd0);
    chk("restart_cur", {37'd0, cur_a[0]}, 40'd0);
    wait_en(0, 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_en",   {36'd0, en_a[0]},  40'd0);
    chk("midrst_lrst", {36'd0, rst_a[0]}, 40'd0);
    chk("midrst_busy", {39'd0, busy_a[0]}, 40'd0);
    chk("midrst_cur",  {37'd0, cur_a[0]}, 40'd0);
    chk("midrst_cyc",  {8'd0, cyc_a[0]},  40'd0);

    // Stall five cycles in RUN and five in DRAIN of layer 0.
    push_rst(0, 4'b0001);
    push_en(0, 4'b0001, 3); push_en(0, 4'b0001, 8); push_en(0, 4'b0001, 2);
    for (int i = 1; i < 4; i++) begin push_rst(0, 4'(1 << i)); push_en(0, 4'(1 << i), 13); end
    push_done(0, 52, 4, 3, 1'b0);
    pulse_start(0);
    wait_en(0, 0);
    repeat (3) tick();
    stall = 1'b1;
    repeat (5) tick();
    stall = 1'b0;
    repeat (6) tick();
    fin = 4'b0001;
    tick();
    fin = 4'd0;
    tick();
    stall = 1'b1;
    repeat (5) tick();
    stall = 1'b0;
    for (int i = 1; i < 4; i++) run_layer(0, i, 10);
    wait_done(0);

    // Skip mask 0101, INIT_BUF=1.
    push_rst(1, 4'b0001); push_en(1, 4'b0001, 13);
    push_rst(1, 4'b0100); push_en(1, 4'b0100, 13);
    push_done(1, 26, 2, 3, 1'b1);
    pulse_start(1);
    run_layer(1, 0, 10);
    run_layer(1, 2, 10);
    wait_done(1);

    // DRAIN_CYCLES = 0.
    for (int i = 0; i < 4; i++) begin push_rst(2, 4'(1 << i)); push_en(2, 4'(1 << i), 10); end
    push_done(2, 40, 4, 3, 1'b0);
    pulse_start(2);
    run_layer(2, 0, 10);
    chk("d0_next_en",   {36'd0, en_a[2]}, 40'd0);
    chk("d0_next_busy", {39'd0, busy_a[2]}, 40'd1);
    for (int i = 1; i < 4; i++) run_layer(2, i, 10);
    wait_done(2);

    // Empty mask: four SEEK cycles then DONE.
    push_done(3, 0, 0, 3, 1'b0);
    pulse_start(3);
    repeat (3) tick();
    chk("empty_done_early", {39'd0, done_a[3]}, 40'd0);
    tick();
    chk("empty_done", {39'd0, done_a[3]}, 40'd1);
    chk("empty_en",   {36'd0, en_a[3]},   40'd0);
    repeat (4) tick();

    chk("queue_empty", 40'(exp_q.size()), 40'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/net_sequencer.md
# net_sequencer

Top-level layer scheduler for the CNN accelerator. It runs a fixed chain of layer controllers (conv/pool/fc controllers, each with sync `reset`, level `en_ctrl`, and `finish` ports) one at a time. For each layer it clears the controller, enables it, waits for `finish` plus a write-back drain, then swaps the ping-pong feature-map buffers. It also gates all layer enables on a memory stall and counts cycles.

## Interface
- `NUM_LAYERS`, 4: number of layer controllers in the chain, 1..8.
- `ACTIVE_MASK`, 4'b1111: bit i = 1 means layer i runs; 0 means it is skipped.
- `DRAIN_CYCLES`, 3: cycles that `en_ctrl` stays asserted after `finish`, to flush the sat/write pipeline; 0..15.
- `INIT_BUF`, 0: `buf_sel` value after reset and at every `start`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high; clock `clk`.
- `start` in 1: single-cycle request to run the network; sampled only in IDLE.
- `abort` in 1: cancel the current run; highest priority.
- `stall` in 1: memory not ready; deasserts all `en_ctrl` and freezes the sequencer.
- `finish_in` in NUM_LAYERS: per-layer `finish` from the layer controllers.
- `en_ctrl` out NUM_LAYERS: per-layer enable, at most one bit high (one-hot or zero).
- `layer_rst` out NUM_LAYERS: per-layer synchronous clear.
- `buf_sel` out 1: current layer reads buffer `buf_sel` and writes buffer `~buf_sel`.
- `cur_layer` out 3: index of the layer being run.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the network completes.
- `cycle_count` out 32: RUN+DRAIN cycles of the current or last run.

## Operation
States: IDLE, SEEK, CLEAR, RUN, DRAIN, NEXT, DONE, ABORT.

- **IDLE**
  - `start`=1 loads `cur_layer`=0, `buf_sel`=`INIT_BUF`, `cycle_count`=0, then goes to SEEK.
  - `start` in any other state is ignored.
- **SEEK**
  - If `ACTIVE_MASK[cur_layer]`=1, go to CLEAR.
  - Else if `cur_layer`=NUM_LAYERS-1, go to DONE.
  - Else increment `cur_layer` and stay in SEEK. `buf_sel` is not toggled for skipped layers.
- **CLEAR**: `layer_rst[cur_layer]`=1 for exactly one cycle, then go to RUN.
- **RUN**
  - `en_ctrl[cur_layer]` = `~stall`.
  - `finish_in[cur_layer]`=1 loads the drain counter with DRAIN_CYCLES, then goes to DRAIN; with DRAIN_CYCLES=0 it goes directly to NEXT.
  - `finish_in` bits of other layers are ignored.
- **DRAIN**
  - `en_ctrl[cur_layer]` = `~stall`.
  - The counter decrements only when `stall`=0.
  - When the counter reaches 0 the state goes to NEXT, so `en_ctrl` is high for exactly DRAIN_CYCLES non-stalled cycles.
- **NEXT**
  - Toggle `buf_sel`.
  - If `cur_layer`=NUM_LAYERS-1, go to DONE; else increment `cur_layer` and go to SEEK.
- **DONE**: `done`=1 for one cycle, then go to IDLE. `cur_layer`, `buf_sel` and `cycle_count` hold their values until the next `start`.
- **ABORT**: `layer_rst` all ones for one cycle, then go to IDLE. `done` is not pulsed.
- **Abort rule**: `abort`=1 in any non-IDLE state goes to ABORT on the next edge and overrides every other transition. `abort` in IDLE is ignored.
- **Stall rule**: in SEEK, CLEAR and NEXT, `stall` has no effect; stall freezes only RUN and DRAIN.
- **`cycle_count`**: increments in every RUN/DRAIN cycle with `stall`=0 and saturates at 32'hFFFF_FFFF.
- **Empty mask**: `ACTIVE_MASK`=0 gives IDLE -> SEEK -> ... -> DONE with no `en_ctrl` or `layer_rst` activity.

## Timing
- **Reset values**:
  - State IDLE.
  - `en_ctrl`=0, `layer_rst`=0, `buf_sel`=`INIT_BUF`, `cur_layer`=0, `busy`=0, `done`=0, `cycle_count`=0.
- **Reset mid-run** behaves exactly like reset from IDLE. Layer controllers share `reset`, so the sequencer does not assert `layer_rst` on reset.
- All outputs are registered or decoded only from state and `cur_layer`, with one exception: `en_ctrl` is combinationally ANDed with `~stall`.
- **Start latency** (`start` sampled at edge 0, layer 0 active):
  - SEEK in cycle 1.
  - `layer_rst[0]` high in cycle 2.
  - `en_ctrl[0]` high from cycle 3.
- **Finish-to-next-layer latency** (no stall):
  - `finish_in` seen in RUN at edge t.
  - DRAIN from t+1 to t+DRAIN_CYCLES.
  - NEXT at t+DRAIN_CYCLES+1.
  - SEEK at +2, CLEAR at +3.
- `en_ctrl` is low in SEEK, CLEAR, NEXT, DONE, ABORT and IDLE.
- **Overlap rule**: `layer_rst` and `en_ctrl` are never high for the same layer in the same cycle.

## Test plan
1. **Full run, no stall.** NUM_LAYERS=4, mask 1111, DRAIN_CYCLES=3, each `finish_in` pulsed 10 cycles after its `en_ctrl` rises.
   - Each layer sees 1 `layer_rst` cycle, then 10 RUN cycles plus 3 DRAIN cycles of `en_ctrl`.
   - `buf_sel` toggles 4 times, ending at `INIT_BUF`.
   - `done` pulses once; `cycle_count`=52.
2. **Skip mask.** Mask 0101.
   - Only layers 0 and 2 get `layer_rst` and `en_ctrl`.
   - `buf_sel` toggles twice.
   - `cur_layer` ends at 3.
3. **Stall.** Hold `stall`=1 for 5 cycles in the middle of RUN and again in DRAIN.
   - `en_ctrl` is low exactly during the stall cycles.
   - The drain still gives 3 enabled cycles.
   - `cycle_count` excludes the stalled cycles.
4. **Abort.** Assert `abort` during DRAIN of layer 1, together with `start` in the same cycle.
   - Next cycle: `layer_rst`=4'b1111 and `en_ctrl`=0.
   - Then IDLE, with no `done` pulse.
   - A new `start` restarts at layer 0 with `buf_sel`=`INIT_BUF`.
5. **Spurious inputs.**
   - `finish_in[2]` pulsed while running layer 0 is ignored.
   - `start` pulsed while `busy`=1 is ignored.
   - Reset asserted mid-RUN: all outputs at reset values on the next cycle.
6. **Corner parameters.**
   - DRAIN_CYCLES=0: NEXT follows RUN immediately.
   - Mask 0000: `done` pulses in the cycle after SEEK finishes, with no `en_ctrl` activity.
